// File: rtl/cpu_types_pkg.sv
// Shared definitions for the instruction cache: address split and frame layout.
package cpu_types_pkg;
    localparam int IIDX_W = 4;
    localparam int ITAG_W = 32 - IIDX_W - 2;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } icache_frame_t;
endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a combinational hit path
// and a two-state refill FSM towards the memory controller.
module icache
    import cpu_types_pkg::*;
#(
    parameter int ISETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] misscnt
);
    typedef enum logic {IDLE, FETCH} state_t;

    state_t        state;
    icache_frame_t frames [ISETS];
    icachef_t      req;
    icachef_t      missaddr;
    logic          hit;

    assign req  = icachef_t'(imemaddr);
    assign hit  = imemREN && (state == IDLE) && frames[req.idx].valid
                  && (frames[req.idx].tag == req.tag);
    assign ihit = hit;
    assign imemload = hit ? frames[req.idx].data : '0;
    // iREN is a register, so iaddr drops to zero with it on an asynchronous reset.
    assign iaddr = iREN ? missaddr : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            iREN     <= 1'b0;
            misscnt  <= '0;
            missaddr <= '0;
            for (int i = 0; i < ISETS; i++) begin
                frames[i].valid <= 1'b0;
            end
        end else begin
            if (iflush) begin
                for (int i = 0; i < ISETS; i++) begin
                    frames[i].valid <= 1'b0;
                end
            end
            case (state)
                IDLE: begin
                    if (imemREN && !hit) begin
                        missaddr <= icachef_t'(req & 32'hFFFF_FFFC);
                        misscnt  <= misscnt + 32'd1;
                        iREN     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        // A flush in the fill cycle leaves the freshly written frame invalid.
                        frames[missaddr.idx].valid <= !iflush;
                        frames[missaddr.idx].tag   <= missaddr.tag;
                        frames[missaddr.idx].data  <= iload;
                        iREN  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    iREN  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: table-driven access sequences with a fill scoreboard
// plus hand-written redirect, flush-vs-fill and asynchronous-reset sequences.
module tb_icache;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        iflush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] misscnt;

    always #5 CLK = ~CLK;

    icache dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
        .iload(iload), .misscnt(misscnt)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        int          wt;
        bit          miss;
    } vec_t;

    sb_t  exp_q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory contents seen by the refill port; word 0 holds 0x8C010004.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h8C01_0004;
    endfunction

    task automatic reset_dut();
        nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0; iwait = 1'b1; iload = '0;
        exp_q.delete();
        #1;
        check("rst_ihit", {31'b0, ihit}, 32'd0);
        check("rst_iREN", {31'b0, iREN}, 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        check("rst_misscnt", misscnt, 32'd0);
        check("rst_imemload", imemload, 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // One fetch: drives the request, acts as memory for any refill, checks data via the
    // scoreboard, whether a refill happened, the latency and the miss counter.
    task automatic access(input logic [31:0] a, input int wt, input bit exp_miss,
                          input logic [31:0] exp_cnt);
        bit  saw_fetch = 1'b0;
        bit  done = 1'b0;
        int  fc = 0;
        int  cyc = 0;
        sb_t e;
        @(posedge CLK); #1;
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
        exp_q.push_back('{a & 32'hFFFF_FFFC, memw(a & 32'hFFFF_FFFC)});
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            cyc++;
            if (ihit) begin
                e = exp_q.pop_front();
                check($sformatf("data@%0h", a), imemload, e.data);
                done = 1'b1;
            end else if (iREN) begin
                if (!saw_fetch) check($sformatf("iaddr@%0h", a), iaddr, e.addr | (a & 32'hFFFF_FFFC));
                saw_fetch = 1'b1;
                fc++;
                if (fc > wt) begin
                    iwait = 1'b0;
                    iload = memw(iaddr);
                end else begin
                    iwait = 1'b1;
                end
            end else begin
                iwait = 1'b1;
            end
        end
        if (!done) begin
            check($sformatf("timeout@%0h", a), 32'd0, 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        check($sformatf("miss@%0h", a), {31'b0, saw_fetch}, {31'b0, exp_miss});
        check($sformatf("latency@%0h", a), cyc, exp_miss ? wt + 3 : 1);
        check($sformatf("misscnt@%0h", a), misscnt, exp_cnt);
    endtask

    initial begin
        logic [31:0] cnt;

        // Cold miss with three wait cycles.
        reset_dut();
        access(32'h0, 3, 1'b1, 32'd1);

        // Sweep twice, then conflicts on index 0.
        reset_dut();
        for (int i = 0; i < 16; i++) tbl.push_back('{32'(i * 4), i % 3, 1'b1});
        for (int i = 0; i < 16; i++) tbl.push_back('{32'(i * 4) | 32'(i % 4), 0, 1'b0});
        tbl.push_back('{32'h40, 1, 1'b1});
        tbl.push_back('{32'h40, 0, 1'b0});
        tbl.push_back('{32'h00, 0, 1'b1});
        tbl.push_back('{32'h04, 0, 1'b0});
        tbl.push_back('{32'h40, 2, 1'b1});
        cnt = 0;
        foreach (tbl[i]) begin
            if (tbl[i].miss) cnt++;
            access(tbl[i].addr, tbl[i].wt, tbl[i].miss, cnt);
        end

        // Redirect during a fetch.
        reset_dut();
        @(posedge CLK); #1;
        imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1;
        @(negedge CLK);
        check("rd_idle_ihit", {31'b0, ihit}, 32'd0);
        check("rd_idle_iREN", {31'b0, iREN}, 32'd0);
        @(posedge CLK); #1;
        imemaddr = 32'h20;
        @(negedge CLK);
        check("rd_f1_iREN", {31'b0, iREN}, 32'd1);
        check("rd_f1_iaddr", iaddr, 32'h10);
        check("rd_f1_ihit", {31'b0, ihit}, 32'd0);
        @(negedge CLK);
        check("rd_f2_iaddr", iaddr, 32'h10);
        iwait = 1'b0; iload = memw(32'h10);
        @(posedge CLK); #1;
        iwait = 1'b1;
        @(negedge CLK);
        check("rd_back_ihit", {31'b0, ihit}, 32'd0);
        check("rd_back_iREN", {31'b0, iREN}, 32'd0);
        check("rd_back_cnt", misscnt, 32'd1);
        @(negedge CLK);
        check("rd_new_iREN", {31'b0, iREN}, 32'd1);
        check("rd_new_iaddr", iaddr, 32'h20);
        check("rd_new_cnt", misscnt, 32'd2);
        iwait = 1'b0; iload = memw(32'h20);
        @(negedge CLK);
        check("rd_new_ihit", {31'b0, ihit}, 32'd1);
        check("rd_new_data", imemload, memw(32'h20));
        access(32'h10, 0, 1'b0, 32'd2);

        // Flush in the same cycle as a fill.
        reset_dut();
        access(32'h0, 0, 1'b1, 32'd1);
        access(32'h4, 0, 1'b1, 32'd2);
        @(posedge CLK); #1;
        imemaddr = 32'h8;
        @(negedge CLK);
        check("fl_idle_iREN", {31'b0, iREN}, 32'd0);
        @(negedge CLK);
        check("fl_fetch_iaddr", iaddr, 32'h8);
        iwait = 1'b0; iload = memw(32'h8); iflush = 1'b1;
        @(posedge CLK); #1;
        iflush = 1'b0; iwait = 1'b1; imemREN = 1'b0;
        access(32'h8, 0, 1'b1, 32'd4);
        access(32'h0, 0, 1'b1, 32'd5);
        access(32'h4, 1, 1'b1, 32'd6);

        // Asynchronous reset in the middle of a fetch.
        reset_dut();
        access(32'h0, 0, 1'b1, 32'd1);
        @(posedge CLK); #1;
        imemaddr = 32'hC;
        @(negedge CLK);
        check("ar_miss_ihit", {31'b0, ihit}, 32'd0);
        @(posedge CLK); #1;
        imemaddr = 32'h0;
        @(negedge CLK);
        check("ar_fetch_iREN", {31'b0, iREN}, 32'd1);
        check("ar_fetch_iaddr", iaddr, 32'hC);
        check("ar_fetch_ihit", {31'b0, ihit}, 32'd0);
        #2;
        nRST = 1'b0;
        #1;
        check("ar_iREN", {31'b0, iREN}, 32'd0);
        check("ar_iaddr", iaddr, 32'd0);
        check("ar_misscnt", misscnt, 32'd0);
        check("ar_ihit", {31'b0, ihit}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1; imemREN = 1'b0; iwait = 1'b1;
        access(32'h0, 1, 1'b1, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
